ps2_keyboard_controller: RTL and testbench

- Receives PS/2 keyboard frames in the system clock domain: synchronises ps2_clock/ps2_data, deserialises 11-bit frames and validates start, parity and stop bits.
- Folds the 0xE0 (extended) and 0xF0 (break) prefix bytes into flags on the following scancode.
- Queues 10-bit key events in a first-word-fall-through FIFO that the CPU I/O logic drains with a read strobe.
- Sits between the keyboard connector pins and the CPU peripheral bus.

---
 rtl/ps2_keyboard_controller.sv | 167 ++++++++++++++++
 tb/tb_ps2_keyboard_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_controller.sv
// PS/2 keyboard receiver: synchronises the connector pins, deserialises and validates
// 11-bit frames, folds E0/F0 prefixes into flags, and queues key events in an FWFT FIFO.
module ps2_keyboard_controller #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    input  logic                          read,
    input  logic                          clear_errors,
    output logic [9:0]                    key_data,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

    // Pin synchronisers: [0] meta, [1] synced; the clock chain keeps [2] as the previous synced value.
    logic [2:0]    ps2_clk_sync_q, ps2_clk_sync_d;
    logic [1:0]    ps2_dat_sync_q, ps2_dat_sync_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, frame_error_q, frame_error_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic       fall_edge, bit_in;
    logic       push, frame_err_evt, do_read, do_write, fifo_full, ovf_evt;
    logic [9:0] push_data;

    assign fall_edge = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
    assign bit_in    = ps2_dat_sync_q[1];

    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so no path can leave a variable unassigned and infer a latch.
    always_comb begin
        ps2_clk_sync_d = {ps2_clk_sync_q[1:0], ps2_clock};
        ps2_dat_sync_d = {ps2_dat_sync_q[0], ps2_data};
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        idle_cnt_d     = idle_cnt_q;
        ext_d          = ext_q;
        rel_d          = rel_q;
        push           = 1'b0;
        push_data      = '0;
        frame_err_evt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_edge && !bit_in) begin
                    bit_cnt_d  = 4'd1;
                    idle_cnt_d = '0;
                    state_d    = RECEIVE;
                end
            end
            RECEIVE: begin
                if (fall_edge) begin
                    // LSB-first: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
                    shift_d    = {bit_in, shift_q[9:1]};
                    idle_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    frame_err_evt = 1'b1;
                    ext_d         = 1'b0;
                    rel_d         = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!(^shift_q[8:0]) || !shift_q[9]) begin
                    frame_err_evt = 1'b1;
                    ext_d         = 1'b0;
                    rel_d         = 1'b0;
                end else if (shift_q[7:0] == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (shift_q[7:0] == 8'hF0) begin
                    rel_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_data = {ext_q, rel_q, shift_q[7:0]};
                    ext_d     = 1'b0;
                    rel_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A read frees the head slot this cycle, so a push into a full FIFO still lands.
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        do_read   = read && (count_q != '0);
        do_write  = push && (!fifo_full || do_read);
        ovf_evt   = push && fifo_full && !do_read;
        wr_ptr_d  = wr_ptr_q + AW'(do_write);
        rd_ptr_d  = rd_ptr_q + AW'(do_read);
        count_d   = count_q + CW'(do_write) - CW'(do_read);

        overflow_d    = (overflow_q && !clear_errors) || ovf_evt;
        frame_error_d = (frame_error_q && !clear_errors) || frame_err_evt;
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_clk_sync_q <= '1;
            ps2_dat_sync_q <= '1;
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            idle_cnt_q     <= '0;
            ext_q          <= 1'b0;
            rel_q          <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            ps2_clk_sync_q <= ps2_clk_sync_d;
            ps2_dat_sync_q <= ps2_dat_sync_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            idle_cnt_q     <= idle_cnt_d;
            ext_q          <= ext_d;
            rel_q          <= rel_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            frame_error_q  <= frame_error_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; key_data is masked while empty.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign key_valid   = (count_q != '0);
    assign key_data    = key_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// Self-checking bench for ps2_keyboard_controller: directed scenarios plus randomized
// frames compared against a frame-level queue model of the key event stream.
module tb_ps2_keyboard_controller;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 5;

    logic       clock = 1'b0;
    logic       reset, ps2_clock, ps2_data, read, clear_errors;
    logic [9:0] key_data;
    logic       key_valid, overflow, frame_error;
    logic [3:0] fifo_count;

    ps2_keyboard_controller #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
        .read(read), .clear_errors(clear_errors), .key_data(key_data),
        .key_valid(key_valid), .fifo_count(fifo_count), .overflow(overflow),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: event queue plus prefix and sticky flags, updated per whole frame.
    logic [9:0] model_q[$];
    bit m_ext, m_rel, m_ovf, m_ferr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_ferr = 1; m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            if (model_q.size() == DEPTH) m_ovf = 1;
            else model_q.push_back({m_ext, m_rel, b});
            m_ext = 0; m_rel = 0;
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clock); ps2_data = b;
        repeat (HALF - 1) @(negedge clock);
        ps2_clock = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clock = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) drive_bit(f[i]);
        repeat (3) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        send_bits(make_frame(b, bad), 11);
        model_frame(b, bad);
    endtask

    // Drives 10 bits then the stop edge, leaving ps2_clock low right after its fall.
    task automatic send_to_stop_edge(input logic [10:0] f);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        @(negedge clock); ps2_data = f[10];
        repeat (HALF - 1) @(negedge clock);
        ps2_clock = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [9:0] exp_kd;
        exp_kd = (model_q.size() != 0) ? model_q[0] : 10'h0;
        check({tag, ".key_valid"},   key_valid,   (model_q.size() != 0));
        check({tag, ".fifo_count"},  fifo_count,  model_q.size());
        check({tag, ".key_data"},    key_data,    exp_kd);
        check({tag, ".overflow"},    overflow,    m_ovf);
        check({tag, ".frame_error"}, frame_error, m_ferr);
    endtask

    task automatic pop();
        @(negedge clock); read = 1'b1;
        @(negedge clock); read = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && model_q.size() != 0; i++) begin
            check({tag, ".head"}, key_data, model_q[0]);
            pop();
        end
        check_state({tag, ".empty"});
    endtask

    task automatic clr();
        @(negedge clock); clear_errors = 1'b1;
        @(negedge clock); clear_errors = 1'b0;
        m_ovf = 0; m_ferr = 0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        bit          bad;

        reset = 1'b1; ps2_clock = 1'b1; ps2_data = 1'b1; read = 1'b0; clear_errors = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_state("reset");

        // First frame with exact latency from the stop-bit pin edge.
        send_to_stop_edge(make_frame(8'h1C, 0));
        repeat (3) @(posedge clock);
        #1 check("lat_pre", key_valid, 0);
        @(posedge clock);
        #1 check("lat_post", key_valid, 1);
        @(negedge clock); ps2_clock = 1'b1;
        repeat (3) @(negedge clock);
        model_frame(8'h1C, 0);
        check_state("first");
        check("first.data", key_data, 10'h01C);
        pop();
        check_state("first.read");
        pop();
        check_state("read_empty");

        // Extended release sequence, then flags cleared for a plain make code.
        send_byte(8'hE0, 0);
        check_state("after_e0");
        send_byte(8'hF0, 0);
        check_state("after_f0");
        send_byte(8'h74, 0);
        check("ext_rel.data", key_data, 10'h374);
        send_byte(8'h74, 0);
        check_state("plain74");
        drain("ext_rel");

        // Parity error, clear, then normal reception.
        send_byte(8'h1C, 1);
        check_state("parity_err");
        clr();
        check_state("parity_clr");
        send_byte(8'h1C, 0);
        check_state("after_err");
        drain("after_err");

        // Release prefix followed by an abandoned partial frame.
        send_byte(8'hF0, 0);
        send_bits(make_frame(8'h1C, 0), 6);
        repeat (TMO + 20) @(negedge clock);
        m_ferr = 1; m_ext = 0; m_rel = 0;
        check_state("timeout");
        send_byte(8'h1C, 0);
        check("timeout.flags_cleared", key_data, 10'h01C);
        drain("timeout");
        clr();

        // Overflow on the ninth code, then in-order drain.
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 0);
        check_state("overflow");
        check("overflow.head", key_data, 10'h001);
        drain("overflow");
        clr();

        // Full FIFO with read asserted in the CHECK cycle: push and pop both happen.
        for (int i = 0; i < DEPTH; i++) send_byte(8'h11 + 8'(i), 0);
        check_state("full");
        send_to_stop_edge(make_frame(8'h0A, 0));
        repeat (3) @(posedge clock);
        #1 read = 1'b1;
        @(posedge clock);
        #1 read = 1'b0;
        @(negedge clock); ps2_clock = 1'b1;
        repeat (3) @(negedge clock);
        void'(model_q.pop_front());
        model_frame(8'h0A, 0);
        check_state("full_rw");
        check("full_rw.tail", model_q[DEPTH-1], 10'h00A);
        drain("full_rw");

        // Randomized frames, prefixes, parity errors, reads and clears.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hE0 || b == 8'hF0) b = 8'h5A;
                end
            endcase
            bad = ($urandom_range(0, 7) == 0);
            send_byte(b, bad);
            check_state("rand");
            if ($urandom_range(0, 1) == 0) pop();
            if ($urandom_range(0, 5) == 0) clr();
        end
        drain("rand");
        clr();

        // Reset in the middle of a frame with a non-empty FIFO.
        send_byte(8'h33, 0);
        check_state("pre_reset");
        send_bits(make_frame(8'h44, 0), 5);
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock); reset = 1'b0;
        model_q.delete();
        m_ext = 0; m_rel = 0; m_ovf = 0; m_ferr = 0;
        @(negedge clock);
        check_state("mid_reset");
        send_byte(8'h1C, 0);
        check_state("post_reset");
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
